// File: rtl/conv_pkg.sv
// Shared state encoding and width defaults for the convolution MAC sequencer.
package conv_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} seqStateT;
endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Bundle between the sequencer, its window loader, the tap buffers and the output writer.
interface conv_mac_sequencer_if import conv_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              Start;
  logic              Busy;
  logic              TapEn;
  logic [ADDR_W-1:0] TapAddr;
  logic [DATA_W-1:0] ProdIn;
  logic [DATA_W-1:0] Result;
  logic              ResultValid;
  logic              ResultReady;
  logic              Overflow;

  // Result/Overflow transfer on a rising edge where ResultValid and ResultReady are both high;
  // until then ResultValid stays high and Result/Overflow hold their values.
  modport master (
    input  Start, ProdIn, ResultReady,
    output Busy, TapEn, TapAddr, Result, ResultValid, Overflow
  );
  modport slave (
    output Start, ProdIn, ResultReady,
    input  Busy, TapEn, TapAddr, Result, ResultValid, Overflow
  );
endinterface

// File: rtl/conv_acc_add.sv
// Two's-complement adder with signed-overflow detection for the running sum.
module conv_acc_add import conv_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Sum,
  output logic              Ovf
);
  assign Sum = A + B;
  assign Ovf = (A[DATA_W-1] == B[DATA_W-1]) && (Sum[DATA_W-1] != A[DATA_W-1]);
endmodule

// File: rtl/conv_mac_sequencer.sv
// Issues one pixel's tap addresses, accumulates the returned products and
// presents the sum on a valid/ready port.
module conv_mac_sequencer import conv_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int KERNEL_TAPS = 9,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PROD_LAT    = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  conv_mac_sequencer_if.master  bus,
  output seqStateT              DbgState
);
  localparam int CNT_W = $clog2(PROD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(KERNEL_TAPS - 1);
  localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(PROD_LAT - 1);

  seqStateT            state;
  logic                busyQ;
  logic                tapEnQ;
  logic                validQ;
  logic                ovfQ;
  logic [ADDR_W-1:0]   tapAddrQ;
  logic [CNT_W-1:0]    drainCnt;
  logic [PROD_LAT-1:0] prodPipe;
  logic [PROD_LAT:0]   pipeShift;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   accSum;
  logic                addOvf;
  logic                prodValid;

  // The pipe mirrors TapEn delayed by PROD_LAT, so its tail marks the cycle a product lands.
  assign pipeShift = {prodPipe, tapEnQ};
  assign prodValid = prodPipe[PROD_LAT-1];

  conv_acc_add #(.DATA_W(DATA_W)) uAdd (
    .A   (acc),
    .B   (bus.ProdIn),
    .Sum (accSum),
    .Ovf (addOvf)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      busyQ    <= 1'b0;
      tapEnQ   <= 1'b0;
      validQ   <= 1'b0;
      ovfQ     <= 1'b0;
      tapAddrQ <= '0;
      drainCnt <= '0;
      prodPipe <= '0;
      acc      <= '0;
    end else begin
      prodPipe <= pipeShift[PROD_LAT-1:0];
      if (prodValid) begin
        acc <= accSum;
        if (addOvf) ovfQ <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.Start) begin
            acc      <= '0;
            ovfQ     <= 1'b0;
            tapAddrQ <= '0;
            tapEnQ   <= 1'b1;
            busyQ    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (tapAddrQ == LAST_TAP) begin
            tapEnQ   <= 1'b0;
            tapAddrQ <= '0;
            drainCnt <= '0;
            state    <= DRAIN;
          end else begin
            tapAddrQ <= tapAddrQ + 1'b1;
          end
        end
        DRAIN: begin
          // The final product is added on the same edge that enters HOLD.
          if (drainCnt == LAST_DRAIN) begin
            validQ <= 1'b1;
            state  <= HOLD;
          end else begin
            drainCnt <= drainCnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.ResultReady) begin
            validQ <= 1'b0;
            busyQ  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy        = busyQ;
  assign bus.TapEn       = tapEnQ;
  assign bus.TapAddr     = tapAddrQ;
  assign bus.Result      = acc;
  assign bus.ResultValid = validQ;
  assign bus.Overflow    = ovfQ;
  assign DbgState        = state;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Random-stimulus bench for conv_mac_sequencer across three tap/latency configurations.
module tb_conv_mac_sequencer;
  import conv_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 1;

  typedef struct packed {
    logic          busy;
    logic          tapEn;
    logic [AW-1:0] tapAddr;
    logic [DW-1:0] result;
    logic          valid;
    logic          ovf;
    seqStateT      st;
  } obsT;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  conv_mac_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) busA (), busB (), busC ();
  seqStateT stA, stB, stC;

  conv_mac_sequencer #(.DATA_W(DW), .KERNEL_TAPS(9), .ADDR_W(AW), .PROD_LAT(1))
    dutA (.Clk(Clk), .Reset(Reset), .bus(busA), .DbgState(stA));
  conv_mac_sequencer #(.DATA_W(DW), .KERNEL_TAPS(2), .ADDR_W(AW), .PROD_LAT(3))
    dutB (.Clk(Clk), .Reset(Reset), .bus(busB), .DbgState(stB));
  conv_mac_sequencer #(.DATA_W(DW), .KERNEL_TAPS(1), .ADDR_W(AW), .PROD_LAT(2))
    dutC (.Clk(Clk), .Reset(Reset), .bus(busC), .DbgState(stC));

  int numChecks = 0;
  int numErrors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] tbl [3][16];
  logic          enH [3][8];
  logic [AW-1:0] adH [3][8];
  int            tapCnt [3];

  function automatic int tapsOf(int i);
    case (i) 0: return 9; 1: return 2; default: return 1; endcase
  endfunction

  function automatic int latOf(int i);
    case (i) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction

  function automatic obsT obs(int i);
    obsT o;
    case (i)
      0: o = '{busA.Busy, busA.TapEn, busA.TapAddr, busA.Result, busA.ResultValid, busA.Overflow, stA};
      1: o = '{busB.Busy, busB.TapEn, busB.TapAddr, busB.Result, busB.ResultValid, busB.Overflow, stB};
      default: o = '{busC.Busy, busC.TapEn, busC.TapAddr, busC.Result, busC.ResultValid, busC.Overflow, stC};
    endcase
    return o;
  endfunction

  task automatic drive(int i, logic start, logic ready);
    case (i)
      0: begin busA.Start = start; busA.ResultReady = ready; end
      1: begin busB.Start = start; busB.ResultReady = ready; end
      default: begin busC.Start = start; busC.ResultReady = ready; end
    endcase
  endtask

  task automatic setProd(int i, logic [DW-1:0] v);
    case (i)
      0: busA.ProdIn = v;
      1: busB.ProdIn = v;
      default: busC.ProdIn = v;
    endcase
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tagOf(int i, string s);
    return $sformatf("%s[%0d]", s, i);
  endfunction

  // Buffer model: returns tbl[addr] exactly PROD_LAT cycles after the tap, noise otherwise.
  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int d = 7; d > 0; d--) begin
        enH[i][d] = enH[i][d-1];
        adH[i][d] = adH[i][d-1];
      end
      enH[i][0] = obs(i).tapEn;
      adH[i][0] = obs(i).tapAddr;
      if (obs(i).tapEn) tapCnt[i]++;
      setProd(i, enH[i][latOf(i)] ? tbl[i][adH[i][latOf(i)]] : $urandom());
    end
  end

  // Reference: exact integer sum of the taps, wrapped, with overflow on any partial step.
  function automatic logic [DW:0] modelPixel(int i);
    longint s;
    int     acc = 0;
    bit     ovf = 1'b0;
    for (int k = 0; k < tapsOf(i); k++) begin
      s = longint'(acc) + longint'($signed(tbl[i][k]));
      if (s > MAXV || s < MINV) ovf = 1'b1;
      acc = int'(s);
    end
    return {ovf, acc};
  endfunction

  function automatic logic [DW-1:0] randProd();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return DW'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom();
    endcase
  endfunction

  task automatic randTable(int i);
    for (int k = 0; k < 16; k++) tbl[i][k] = randProd();
  endtask

  task automatic runPixel(int i, int holdCycles, bit pulseStart, bit startOnRelease);
    int n;
    logic [DW:0] e;
    exp_q.push_back(modelPixel(i));
    tapCnt[i] = 0;
    drive(i, 1'b1, 1'b0);
    tick();
    drive(i, 1'b0, 1'b0);
    check(tagOf(i, "first_tap"), {obs(i).busy, obs(i).tapEn, obs(i).tapAddr}, {2'b11, AW'(0)});
    n = 1;
    while (!obs(i).valid && n < 200) begin
      tick();
      n++;
    end
    check(tagOf(i, "latency"), n, tapsOf(i) + latOf(i) + 1);
    e = exp_q.pop_front();
    check(tagOf(i, "result"), obs(i).result, e[DW-1:0]);
    check(tagOf(i, "overflow"), obs(i).ovf, e[DW]);
    check(tagOf(i, "tap_count"), tapCnt[i], tapsOf(i));
    for (int h = 0; h < holdCycles; h++) begin
      drive(i, pulseStart && (h == 1), 1'b0);
      tick();
      check(tagOf(i, "hold_stable"), {obs(i).busy, obs(i).valid, obs(i).result, obs(i).ovf},
            {2'b11, e[DW-1:0], e[DW]});
    end
    drive(i, startOnRelease, 1'b1);
    tick();
    drive(i, 1'b0, 1'b0);
    check(tagOf(i, "release"), {obs(i).busy, obs(i).valid, obs(i).tapEn, obs(i).st},
          {3'b000, IDLE});
  endtask

  task automatic abortAtTap4();
    int n = 0;
    randTable(0);
    drive(0, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0);
    while (obs(0).tapAddr != AW'(4) && n < 50) begin
      tick();
      n++;
    end
    check("abort_reach_tap4", obs(0).tapAddr, 4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_cleared", {obs(0).busy, obs(0).tapEn, obs(0).valid, obs(0).ovf, obs(0).tapAddr,
          obs(0).result, obs(0).st}, {4'b0000, AW'(0), DW'(0), IDLE});
  endtask

  initial begin
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 1'b0);
      setProd(i, '0);
      tapCnt[i] = 0;
      for (int d = 0; d < 8; d++) begin
        enH[i][d] = 1'b0;
        adH[i][d] = '0;
      end
      for (int k = 0; k < 16; k++) tbl[i][k] = '0;
    end
    repeat (2) tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++)
      check(tagOf(i, "reset"), {obs(i).busy, obs(i).tapEn, obs(i).valid, obs(i).ovf, obs(i).tapAddr,
            obs(i).result, obs(i).st}, {4'b0000, AW'(0), DW'(0), IDLE});

    for (int k = 0; k < 9; k++) tbl[0][k] = DW'(k + 1);
    runPixel(0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 9; k++) tbl[0][k] = '1;
    runPixel(0, 2, 1'b0, 1'b0);

    tbl[1][0] = 32'h7FFF_FFFF;
    tbl[1][1] = 32'h7FFF_FFFF;
    runPixel(1, 0, 1'b0, 1'b0);

    randTable(0);
    runPixel(0, 5, 1'b1, 1'b1);
    randTable(0);
    runPixel(0, 0, 1'b0, 1'b0);

    abortAtTap4();
    for (int k = 0; k < 9; k++) tbl[0][k] = DW'(10 * k);
    runPixel(0, 1, 1'b0, 1'b0);

    for (int p = 0; p < 4; p++) begin
      randTable(1);
      runPixel(1, 0, 1'b0, 1'b0);
    end
    for (int p = 0; p < 4; p++) begin
      randTable(2);
      runPixel(2, 0, 1'b0, 1'b0);
    end

    for (int r = 0; r < 24; r++) begin
      int i;
      i = $urandom_range(0, 2);
      randTable(i);
      runPixel(i, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end
endmodule
